// File: rtl/result_stream_fifo_pkg.sv
// result_stream_fifo_pkg: shared widths and packet-FSM state encodings (rev 1.0)
`default_nettype none

package result_stream_fifo_pkg;

  localparam int STREAM_W = 64;
  localparam int RES_W    = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } state_t;

endpackage

`default_nettype wire

// File: rtl/result_stream_fifo_sync_fifo.sv
// sync_fifo: DEPTH x W first-word-fall-through buffer with synchronous flush (rev 1.0)
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  // Guards keep the occupancy consistent even if a caller ignores full/empty.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/result_stream_fifo.sv
// result_stream_fifo: packs result pairs into 64-bit beats and streams a counted packet (rev 1.0)
`default_nettype none

module result_stream_fifo
  import result_stream_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         beat_total,
  input  logic                res_v,
  input  logic [RES_W-1:0]    res_1,
  input  logic [RES_W-1:0]    res_2,
  output logic                res_ready,
  input  logic                dst_ready,
  output logic                dst_valid,
  output logic [STREAM_W-1:0] dst_data,
  output logic                dst_last,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  state_t                state;
  state_t                state_nxt;
  logic [15:0]           total;
  logic [15:0]           wr_cnt;
  logic [15:0]           rd_cnt;
  logic                  run;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic [STREAM_W-1:0]   fifo_q;

  assign run       = (state == S_RUN);
  assign busy      = run;
  assign done      = (state == S_FIN);
  assign res_ready = run & ~full & (wr_cnt < total);
  assign wr_en     = res_v & res_ready;
  assign dst_valid = run & ~empty;
  assign rd_en     = dst_valid & dst_ready;
  assign dst_last  = dst_valid & (rd_cnt == total - 16'd1);
  // Storage is unreset, so the data bus is forced to zero whenever no beat is offered.
  assign dst_data  = dst_valid ? fifo_q : '0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (STREAM_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (start),
    .wr_en   (wr_en),
    .wr_data ({res_2, res_1}),
    .rd_en   (rd_en),
    .rd_data (fifo_q),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A start in any state restarts the packet.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (beat_total != 16'd0) ? S_RUN : S_FIN;
    end else begin
      case (state)
        S_RUN:   if (rd_en && dst_last) state_nxt = S_FIN;
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total  <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      ovf    <= 1'b0;
    end else if (start) begin
      total  <= beat_total;
      wr_cnt <= '0;
      rd_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 16'd1;
      if (rd_en) rd_cnt <= rd_cnt + 16'd1;
      if (run && res_v && !res_ready) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_stream_fifo.sv
// tb_result_stream_fifo: randomized scoreboard bench for result_stream_fifo (rev 1.0)
`default_nettype none

module tb_result_stream_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] beat_total = '0;
  logic        res_v = 1'b0;
  logic [31:0] res_1 = '0;
  logic [31:0] res_2 = '0;
  logic        res_ready;
  logic        dst_ready = 1'b0;
  logic        dst_valid;
  logic [63:0] dst_data;
  logic        dst_last;
  logic        busy;
  logic        done;
  logic        ovf;

  result_stream_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .beat_total (beat_total),
    .res_v      (res_v),
    .res_1      (res_1),
    .res_2      (res_2),
    .res_ready  (res_ready),
    .dst_ready  (dst_ready),
    .dst_valid  (dst_valid),
    .dst_data   (dst_data),
    .dst_last   (dst_last),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet phase, expected beats still buffered, accepted pair count.
  typedef struct {
    logic [63:0] d;
    bit          last;
  } beat_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_FIN = 2;
  beat_t q[$];
  int    m_state = M_IDLE;
  int    m_total = 0;
  int    m_acc   = 0;
  bit    m_ovf   = 0;
  int    pops    = 0;

  initial begin
    int  prev;
    bit  exp_ready, exp_valid, st;
    int  bt;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete(); m_state = M_IDLE; m_acc = 0; m_total = 0; m_ovf = 0;
        continue;
      end
      prev      = m_state;
      exp_ready = (m_state == M_RUN) && (q.size() < DEPTH) && (m_acc < m_total);
      exp_valid = (m_state == M_RUN) && (q.size() > 0);
      chk("res_ready", 64'(res_ready), 64'(exp_ready));
      chk("dst_valid", 64'(dst_valid), 64'(exp_valid));
      chk("dst_last",  64'(dst_last),  64'(exp_valid && q[0].last));
      chk("busy",      64'(busy),      64'(m_state == M_RUN));
      chk("done",      64'(done),      64'(m_state == M_FIN));
      chk("ovf",       64'(ovf),       64'(m_ovf));
      if (m_state == M_RUN && res_v) begin
        if (exp_ready) begin
          q.push_back('{d: {res_2, res_1}, last: (m_acc == m_total - 1)});
          m_acc++;
        end else begin
          m_ovf = 1;
        end
      end
      st = start;
      bt = int'(beat_total);
      #2;
      if (rst) continue;
      if (st) begin
        q.delete(); m_acc = 0; m_total = bt; m_ovf = 0;
        m_state = (bt != 0) ? M_RUN : M_FIN;
      end else if (prev == M_FIN) begin
        m_state = M_IDLE;
      end
    end
  end

  // Monitor: compares the offered beat every cycle, retires it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst || !dst_valid) continue;
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(dst_valid), 64'd0);
        continue;
      end
      chk("dst_data", dst_data, q[0].d);
      if (dst_ready) begin
        pops++;
        if (q[0].last) m_state = M_FIN;
        void'(q.pop_front());
      end
    end
  end

  int rd_mode = 0;  // 0: stall, 1: always ready, 2: toggle, 3: random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0:       dst_ready = 1'b0;
        1:       dst_ready = 1'b1;
        2:       dst_ready = ~dst_ready;
        default: dst_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int bt);
    start = 1'b1; beat_total = 16'(bt); res_v = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    res_v = 1'b1; res_1 = a; res_2 = b;
    tick();
    res_v = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_state != M_IDLE && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 64'(m_state == M_IDLE), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dst_valid"}, 64'(dst_valid), 64'd0);
    chk({tag, "_dst_last"},  64'(dst_last),  64'd0);
    chk({tag, "_dst_data"},  dst_data,       64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_ovf"},       64'(ovf),       64'd0);
    chk({tag, "_res_ready"}, 64'(res_ready), 64'd0);
  endtask

  task automatic basic_packet();
    int p0;
    p0 = pops;
    rd_mode = 1;
    do_start(4);
    for (int i = 0; i < 4; i++) push(32'(i), 32'(i + 'h100));
    wait_idle(20);
    chk("basic_beats", 64'(pops - p0), 64'd4);
  endtask

  initial begin
    int p0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    basic_packet();

    // Backpressure: only DEPTH pairs fit, surplus sets ovf, no last beat.
    rd_mode = 0;
    do_start(20);
    for (int i = 0; i < 20; i++) push($urandom, $urandom);
    chk("bp_ovf", 64'(ovf), 64'd1);
    p0 = pops;
    rd_mode = 1;
    repeat (25) tick();
    chk("bp_beats", 64'(pops - p0), 64'd16);
    chk("bp_busy", 64'(busy), 64'd1);

    // Stall stability under toggling ready.
    rd_mode = 2;
    do_start(2);
    push(32'hAAAA_0001, 32'h5555_0001);
    push(32'hAAAA_0002, 32'h5555_0002);
    wait_idle(40);

    // Zero-beat packet, then surplus pairs.
    rd_mode = 1;
    p0 = pops;
    do_start(0);
    wait_idle(5);
    chk("zero_beats", 64'(pops - p0), 64'd0);
    do_start(1);
    for (int i = 0; i < 3; i++) push($urandom, $urandom);
    wait_idle(20);
    chk("surplus_ovf", 64'(ovf), 64'd1);

    // Restart discards buffered beats.
    rd_mode = 0;
    do_start(8);
    for (int i = 0; i < 3; i++) push(32'hDEAD_0000 + 32'(i), 32'hBEEF_0000);
    p0 = pops;
    do_start(2);
    rd_mode = 1;
    push(32'h1111_1111, 32'h2222_2222);
    push(32'h3333_3333, 32'h4444_4444);
    wait_idle(20);
    chk("restart_beats", 64'(pops - p0), 64'd2);

    // Asynchronous reset in the middle of a packet.
    rd_mode = 0;
    do_start(4);
    push(32'h0BAD_0001, 32'h0BAD_0002);
    push(32'h0BAD_0003, 32'h0BAD_0004);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    basic_packet();

    // Randomized packets with random pushes and ready.
    for (int p = 0; p < 6; p++) begin
      int n;
      rd_mode = 3;
      do_start($urandom_range(1, 24));
      n = 0;
      while (m_state != M_IDLE && n < 300) begin
        res_v = 1'($urandom_range(0, 1));
        res_1 = $urandom;
        res_2 = $urandom;
        tick();
        n++;
      end
      res_v = 1'b0;
      wait_idle(100);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/result_stream_fifo.md
Name: result_stream_fifo

Overview:
Downstream stage between the core's 32-bit result pair (result_1/result_2) and the 64-bit AXI Stream master port. It packs each accepted result pair into one 64-bit beat and buffers beats in a small FIFO. It drives the stream valid/last handshake for a packet of a programmed beat count and reports overflow when the core pushes faster than the stream drains.

Parameters:
DEPTH, 16, FIFO depth in beats; must be a power of 2 and at least 2.
AW, 4, pointer width; equals log2(DEPTH).

Ports:
clk  in  1  stream clock (AXIS_ACLK domain).
rst  in  1  reset; asynchronous, active-high.
start  in  1  one-cycle pulse; begins a packet and latches beat_total.
beat_total  in  16  number of beats in the packet; sampled on start.
res_v  in  1  result pair valid.
res_1  in  32  low word of the beat.
res_2  in  32  high word of the beat.
res_ready  out  1  pair accepted this cycle if res_v is high.
dst_ready  in  1  M_AXIS_TREADY.
dst_valid  out  1  M_AXIS_TVALID.
dst_data  out  64  M_AXIS_TDATA; {res_2, res_1}.
dst_last  out  1  M_AXIS_TLAST.
busy  out  1  high while a packet is in progress.
done  out  1  one-cycle pulse after the last beat handshake.
ovf  out  1  sticky; a pair was dropped.

Behaviour:
- Reset (async, rst=1): state IDLE; pointers and counters 0. All outputs are 0: dst_valid, dst_last, busy, done, ovf, res_ready, dst_data.
- States: IDLE, RUN, FIN.
  - IDLE -> RUN on start with beat_total != 0. The wr_cnt/rd_cnt counters clear, total is latched, and ovf clears.
  - IDLE -> FIN on start with beat_total == 0. This is a zero-beat packet; no beat is emitted.
  - RUN -> FIN in the cycle the beat with dst_last=1 completes its handshake.
  - FIN -> IDLE unconditionally. done=1 only in FIN.
- start while in RUN or FIN: treated as a restart. The FIFO is flushed (pointers reset), counters clear, ovf clears, and the new total is latched. The next state follows the IDLE rules. Beats buffered before the restart are discarded.
- busy = (state == RUN).
- Write side:
  - res_ready = RUN & !full & (wr_cnt < total).
  - A write occurs when res_v & res_ready. mem[wr_ptr] gets {res_2, res_1}; wr_ptr and wr_cnt increment.
  - res_v & !res_ready while in RUN sets ovf. This covers both a full FIFO and surplus pairs beyond total. The pair is dropped.
  - res_v in IDLE or FIN is ignored and does not set ovf.
- Read side:
  - The FIFO is first-word-fall-through: dst_data = mem[rd_ptr] and dst_valid = RUN & !empty.
  - A beat completes on dst_valid & dst_ready; rd_ptr and rd_cnt then increment.
  - dst_last = dst_valid & (rd_cnt == total-1).
  - Latency: a pair written in cycle N into an empty FIFO appears on dst_valid in cycle N+1.
  - dst_data and dst_last must hold stable while dst_valid=1 and dst_ready=0 (AXI Stream rule).
- Occupancy:
  - count of DEPTH+1 values; full = (count == DEPTH), empty = (count == 0).
  - A simultaneous write and read leaves count unchanged and is legal at any fill level except full-with-write, which is blocked by res_ready.
  - Pointers wrap modulo DEPTH.
- Counters: 16-bit, with no wrap inside a packet because they stop at total.

Decomposition:
- Shared package constants: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2; STREAM_W=64; RES_W=32.
- One natural sub-module: sync_fifo. It is a parameterised DEPTH x 64 storage block with FWFT, exposing wr_en, rd_en, full, empty and flush. The packet FSM and counters stay in result_stream_fifo.

Test Plan:
- Basic packet: beat_total=4, start, push 4 pairs (res_1=i, res_2=i+0x100), dst_ready=1 throughout -> 4 beats with dst_data=0x00000100_00000000 ... 0x00000103_00000003, dst_last on beat 4 only, done pulse 1 cycle later, ovf=0.
- Backpressure and full: DEPTH=16, beat_total=20, dst_ready=0, push 20 pairs back-to-back -> res_ready drops after 16 writes, ovf=1; then raise dst_ready -> exactly 16 beats, no dst_last, busy stays 1.
- Stall stability: beat_total=2, push 2, dst_ready toggling 0/1 every cycle -> dst_data/dst_last constant across stalls, dst_last only on beat 2, order preserved.
- Zero and surplus: beat_total=0 with start -> done in the next cycle, dst_valid never 1. Then beat_total=1 with 3 pushes -> 1 beat with dst_last=1, ovf=1.
- Restart: beat_total=8, push 3, start again with beat_total=2 -> old beats never appear, ovf cleared, 2 new beats, last on beat 2.
- Async reset: assert rst mid-packet (between clock edges) -> all outputs 0 immediately without waiting for a clock edge; after release a fresh start behaves as in the basic packet case.
